// File: rtl/boot_arb_pkg.sv
// Shared definitions for the boot memory arbiter: default parameter values
// and the arbiter state encoding.
package boot_arb_pkg;

  localparam int DEF_ADDRESS_WIDTH  = 32;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_RELEASE_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BOOT    = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/boot_write_fifo.sv
// Boot write buffer: holds parsed boot words (address + data) until memory
// accepts them. A push into a full buffer is accepted only when a pop frees
// a slot in the same cycle. Storage is deliberately left unreset; only the
// pointers and the occupancy count are cleared.
module boot_write_fifo #(
  parameter int addr_w = 32,
  parameter int data_w = 16,
  parameter int depth  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [addr_w-1:0] push_addr_i,
  input  logic [data_w-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [addr_w-1:0] head_addr_o,
  output logic [data_w-1:0] head_data_o
);

  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int CNT_W = $clog2(depth) + 1;

  logic [addr_w-1:0] addr_mem_q [depth];
  logic [data_w-1:0] data_mem_q [depth];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push_s;
  logic              do_pop_s;

  assign full_o      = (count_q == CNT_W'(depth));
  assign empty_o     = (count_q == {CNT_W{1'b0}});
  assign do_pop_s    = pop_i & ~empty_o;
  assign do_push_s   = push_i & (~full_o | do_pop_s);
  assign head_addr_o = addr_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];

  // Next pointer and occupancy; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = do_push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = do_pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers, cleared asynchronously so buffered words are discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Word storage, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      addr_mem_q[wr_ptr_q] <= push_addr_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/boot_mem_arbiter.sv
// Boot memory arbiter: shares one memory port between the CPU and a boot
// loader. While booting, the CPU is held and buffered boot words are written
// to memory; after the buffer drains the CPU stays held for release_cycles
// more cycles before control returns to it.
// Optional feature: define BOOT_ARB_CHECKSUM_EN to accumulate a running sum
// of the boot data written; otherwise boot_checksum is tied to zero.
module boot_mem_arbiter
  import boot_arb_pkg::*;
#(
  parameter int address_width  = DEF_ADDRESS_WIDTH,
  parameter int data_width     = DEF_DATA_WIDTH,
  parameter int fifo_depth     = DEF_FIFO_DEPTH,
  parameter int release_cycles = DEF_RELEASE_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     boot_valid,
  input  logic [address_width-1:0] boot_address,
  input  logic [data_width-1:0]    boot_data,
  input  logic                     boot_busy,
  input  logic                     boot_error,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [address_width-1:0] cpu_addr,
  input  logic [data_width-1:0]    cpu_wdata,
  output logic                     cpu_gnt,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [address_width-1:0] mem_addr,
  output logic [data_width-1:0]    mem_wdata,
  input  logic                     mem_ready,
  output logic                     cpu_hold,
  output logic                     boot_done,
  output logic                     overflow,
  output logic                     error_latched,
  output logic [data_width-1:0]    boot_checksum
);

  localparam int CNT_W = $clog2(release_cycles + 1);

  arb_state_e                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       boot_done_q, boot_done_d;
  logic                       overflow_q, overflow_d;
  logic                       error_q, error_d;

  logic                       fifo_full_s;
  logic                       fifo_empty_s;
  logic [address_width-1:0]  head_addr_s;
  logic [data_width-1:0]     head_data_s;
  logic                       in_boot_s;
  logic                       pop_s;
  logic                       drop_s;
  logic                       start_s;

  assign in_boot_s = (state_q == ST_BOOT) || (state_q == ST_DRAIN);
  assign pop_s     = in_boot_s & ~fifo_empty_s & mem_ready;
  assign drop_s    = boot_valid & fifo_full_s & ~pop_s;

  boot_write_fifo #(
    .addr_w (address_width),
    .data_w (data_width),
    .depth  (fifo_depth)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (boot_valid),
    .push_addr_i (boot_address),
    .push_data_i (boot_data),
    .pop_i       (pop_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .head_addr_o (head_addr_s),
    .head_data_o (head_data_s)
  );

  // State transitions, release countdown and completion pulse.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    boot_done_d = 1'b0;
    start_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (boot_busy || !fifo_empty_s) begin
          state_d = ST_BOOT;
          start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BOOT: begin
        if (!boot_busy) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_BOOT;
        end
      end
      ST_DRAIN: begin
        if (boot_busy) begin
          state_d = ST_BOOT;
        end else if (fifo_empty_s) begin
          state_d = ST_RELEASE;
          cnt_d   = CNT_W'(release_cycles - 1);
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_RELEASE: begin
        if (boot_busy) begin
          // A new boot abandons the countdown; no completion is signalled.
          state_d = ST_BOOT;
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d     = ST_IDLE;
          boot_done_d = 1'b1;
        end else begin
          state_d = ST_RELEASE;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Sticky status: a new set wins over the clear at boot start.
  always_comb begin
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (start_s) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (boot_error && (state_q != ST_IDLE)) begin
      error_d = 1'b1;
    end else if (start_s) begin
      error_d = 1'b0;
    end else begin
      error_d = error_q;
    end
  end

  // Memory port steering: CPU passes straight through in IDLE, buffer head while booting.
  always_comb begin
    case (state_q)
      ST_IDLE: begin
        mem_req   = cpu_req;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_gnt   = cpu_req & mem_ready;
      end
      ST_BOOT, ST_DRAIN: begin
        mem_req   = ~fifo_empty_s;
        mem_we    = 1'b1;
        mem_addr  = head_addr_s;
        mem_wdata = head_data_s;
        cpu_gnt   = 1'b0;
      end
      default: begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {address_width{1'b0}};
        mem_wdata = {data_width{1'b0}};
        cpu_gnt   = 1'b0;
      end
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      boot_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      boot_done_q <= boot_done_d;
      overflow_q  <= overflow_d;
      error_q     <= error_d;
    end
  end

  // Hold follows the state register, so an asynchronous reset releases it at once.
  assign cpu_hold      = (state_q != ST_IDLE);
  assign boot_done     = boot_done_q;
  assign overflow      = overflow_q;
  assign error_latched = error_q;

`ifdef BOOT_ARB_CHECKSUM_EN
  logic [data_width-1:0] checksum_q, checksum_d;

  // Running sum of boot data accepted by memory, restarted at each boot entry.
  always_comb begin
    if (start_s) begin
      checksum_d = {data_width{1'b0}};
    end else if (pop_s) begin
      checksum_d = checksum_q + head_data_s;
    end else begin
      checksum_d = checksum_q;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_q <= {data_width{1'b0}};
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign boot_checksum = checksum_q;
`else
  assign boot_checksum = {data_width{1'b0}};
`endif

endmodule
